// File: rtl/riscv_mc_pkg.sv
// Shared constants, FSM/ALU enums and ALU helpers for the multi-cycle RV32I core.
// Optional trap behaviour is selected by the RISCV_MC_TRAP_EN macro (see riscv_mc_core).
package riscv_mc_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    function automatic logic supported(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LUI, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR};
    endfunction

    // funct7 bit 5 selects SUB only for register-register ops; I-type ADDI reuses that bit as immediate.
    function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic f7b5, input logic is_r);
        case (f3)
            3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            default:  return a & b;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mc_regfile.sv
// Integer register file: NUM_REGS x 32, two async read ports, one sync write port.
// x0 and indices at or above NUM_REGS read as zero and ignore writes; no reset.
module riscv_mc_regfile
    import riscv_mc_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    localparam int AW = $clog2(NUM_REGS);
    localparam logic [5:0] LIMIT = 6'(NUM_REGS);

    logic [31:0] regs [NUM_REGS];

    assign rdata1 = (raddr1 != '0 && {1'b0, raddr1} < LIMIT) ? regs[raddr1[AW-1:0]] : '0;
    assign rdata2 = (raddr2 != '0 && {1'b0, raddr2} < LIMIT) ? regs[raddr2[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (we && waddr != '0 && {1'b0, waddr} < LIMIT)
            regs[waddr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/riscv_mc_core.sv
// Multi-cycle RV32I subset core (IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP) with a single memory port.
// Define RISCV_MC_TRAP_EN to halt on unsupported opcodes; otherwise they retire as NOPs.
module riscv_mc_core
    import riscv_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        retire,
    output logic [31:0] pc_o,
    output logic        halted
);

    state_t      state;
    logic [31:0] pc, ir, a, b, imm, res, npc, mdr;
    logic [31:0] imm_d, res_d, npc_d, sum, rdata1, rdata2, rf_wdata;
    logic        rf_we, writes_rd;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] f3;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign pc_o   = pc;

    assign writes_rd = opcode inside {OP_R, OP_I, OP_LUI, OP_LW, OP_JAL, OP_JALR};
    assign rf_we     = (state == S_WB) && writes_rd && (rd != '0);
    assign rf_wdata  = (opcode == OP_LW) ? mdr : res;

    riscv_mc_regfile #(.NUM_REGS(NUM_REGS)) u_rf (
        .clk    (clk),
        .raddr1 (ir[19:15]),
        .raddr2 (ir[24:20]),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (rf_wdata)
    );

    always_comb begin
        case (opcode)
            OP_SW:   imm_d = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OP_BR:   imm_d = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OP_LUI:  imm_d = {ir[31:12], 12'b0};
            OP_JAL:  imm_d = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm_d = {{20{ir[31]}}, ir[31:20]};
        endcase
    end

    // EXEC computes both the rd value (or memory address) and the next PC, so WB only commits.
    assign sum = a + imm;
    always_comb begin
        res_d = '0;
        npc_d = pc + 32'd4;
        case (opcode)
            OP_R:    res_d = alu(alu_decode(f3, ir[30], 1'b1), a, b);
            OP_I:    res_d = alu(alu_decode(f3, ir[30], 1'b0), a, imm);
            OP_LUI:  res_d = imm;
            OP_LW,
            OP_SW:   res_d = sum;
            OP_JAL:  begin res_d = pc + 32'd4; npc_d = pc + imm; end
            OP_JALR: begin res_d = pc + 32'd4; npc_d = sum & 32'hFFFF_FFFE; end
            OP_BR:   if ((a == b) ^ f3[0]) npc_d = pc + imm;
            default: ;
        endcase
    end

`ifdef RISCV_MC_TRAP_EN
    logic halted_q;
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            retire    <= 1'b0;
`ifdef RISCV_MC_TRAP_EN
            halted_q  <= 1'b0;
`endif
        end else begin
            retire <= 1'b0;
            case (state)
                S_IDLE: begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= {pc[31:2], 2'b00};
                    state    <= S_FETCH;
                end
                S_FETCH: if (mem_ready) begin
                    ir      <= mem_rdata;
                    mem_req <= 1'b0;
                    state   <= S_DECODE;
                end
                S_DECODE: begin
                    a     <= rdata1;
                    b     <= rdata2;
                    imm   <= imm_d;
`ifdef RISCV_MC_TRAP_EN
                    if (!supported(opcode)) begin
                        halted_q <= 1'b1;
                        state    <= S_TRAP;
                    end else
                        state <= S_EXEC;
`else
                    state <= S_EXEC;
`endif
                end
                S_EXEC: begin
                    res <= res_d;
                    npc <= npc_d;
                    if (opcode == OP_LW || opcode == OP_SW) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (opcode == OP_SW);
                        mem_addr  <= {res_d[31:2], 2'b00};
                        mem_wdata <= b;
                        state     <= S_MEM;
                    end else
                        state <= S_WB;
                end
                S_MEM: if (mem_ready) begin
                    mem_we <= 1'b0;
                    if (opcode == OP_SW) begin
                        pc       <= npc;
                        retire   <= 1'b1;
                        mem_req  <= 1'b1;
                        mem_addr <= {npc[31:2], 2'b00};
                        state    <= S_FETCH;
                    end else begin
                        mdr     <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= S_WB;
                    end
                end
                S_WB: begin
                    pc       <= npc;
                    retire   <= 1'b1;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= {npc[31:2], 2'b00};
                    state    <= S_FETCH;
                end
                S_TRAP:  state <= S_TRAP;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
